ula_arbiter: RTL and testbench

Shares the single execute-stage ULA (20-bit add/or/and/not unit with operand-equality flag) between N_REQ requesters. Each requester presents an operation through a valid/ready request handshake. The arbiter grants one requester at a time, drives the shared ULA from registered operands, and captures the result. It returns the result to the granted requester through a valid/ready response handshake. It sits between the pipeline's execute-side requesters and the ULA instance.

---
 rtl/ula_pkg.sv | 25 ++
 rtl/ula_arbiter_if.sv | 46 ++++
 rtl/ula_rr_pick.sv | 48 ++++
 rtl/ula_arbiter.sv | 153 +++++++++++++++
 tb/tb_ula_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
//------------------------------------------------------------------------------
// ula_pkg
// Shared ULA width, op-code constants and arbiter FSM state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ula_pkg;

    localparam int ULA_WIDTH = 20;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_OR  = 2'b01;
    localparam logic [1:0] ULA_AND = 2'b10;
    localparam logic [1:0] ULA_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ula_arbiter_if.sv
//------------------------------------------------------------------------------
// ula_arbiter_if
// Request/response handshakes and shared-ULA bus of the ULA arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ula_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 20
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [2*N_REQ-1:0]     req_control;
    logic [WIDTH*N_REQ-1:0] req_opA;
    logic [WIDTH*N_REQ-1:0] req_opB;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_ulaZero;
    logic [1:0]             alu_control;
    logic [WIDTH-1:0]       alu_opA;
    logic [WIDTH-1:0]       alu_opB;
    logic [WIDTH-1:0]       alu_result;
    logic                   alu_ulaZero;
    logic                   busy;

    // Requesters plus the shared ULA instance.
    modport master (
        output req_valid, req_control, req_opA, req_opB, rsp_ready,
               alu_result, alu_ulaZero,
        input  req_ready, rsp_valid, rsp_result, rsp_ulaZero,
               alu_control, alu_opA, alu_opB, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_control, req_opA, req_opB, rsp_ready,
               alu_result, alu_ulaZero,
        output req_ready, rsp_valid, rsp_result, rsp_ulaZero,
               alu_control, alu_opA, alu_opB, busy
    );

endinterface

`default_nettype wire

// File: rtl/ula_rr_pick.sv
//------------------------------------------------------------------------------
// ula_rr_pick
// Combinational winner select: one-hot grant plus binary index.
// ULA_ARB_FIXED_PRIORITY_EN selects lowest-index-wins and removes the pointer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ula_rr_pick #(
    parameter  int N_REQ = 2,
    localparam int IDXW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
`ifndef ULA_ARB_FIXED_PRIORITY_EN
    input  logic [IDXW-1:0]  ptr_i,
`endif
    output logic [N_REQ-1:0] grant_o,
    output logic [IDXW-1:0]  idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ULA_ARB_FIXED_PRIORITY_EN
            j = k;
`else
            // Search wraps around starting at the pointer.
            j = int'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
`endif
            if (!any_o && req_valid_i[j]) begin
                any_o      = 1'b1;
                idx_o      = IDXW'(j);
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ula_arbiter.sv
//------------------------------------------------------------------------------
// ula_arbiter
// Shares one execute-stage ULA between N_REQ requesters (accept/exec/respond).
// Optional macro: ULA_ARB_FIXED_PRIORITY_EN (fixed priority, no pointer).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ula_arbiter
    import ula_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    ula_arbiter_if.slave bus
);

    localparam int IDXW = $clog2(N_REQ);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   gnt_q, gnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              zero_q, zero_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  gnt_oh;
    logic              rsp_take;

    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ-1:0]  rsp_valid;
    logic [1:0]        alu_control;
    logic [WIDTH-1:0]  alu_opA;
    logic [WIDTH-1:0]  alu_opB;

`ifndef ULA_ARB_FIXED_PRIORITY_EN
    logic [IDXW-1:0]   ptr_q, ptr_d;
`endif

    ula_rr_pick #(
        .N_REQ       (N_REQ)
    ) u_pick (
        .req_valid_i (bus.req_valid),
`ifndef ULA_ARB_FIXED_PRIORITY_EN
        .ptr_i       (ptr_q),
`endif
        .grant_o     (pick_oh),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    assign gnt_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
    assign rsp_take = |(bus.rsp_ready & gnt_oh);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ctrl_d      = ctrl_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        zero_d      = zero_q;
`ifndef ULA_ARB_FIXED_PRIORITY_EN
        ptr_d       = ptr_q;
`endif
        req_ready   = '0;
        rsp_valid   = '0;
        alu_control = 2'b00;
        alu_opA     = '0;
        alu_opB     = '0;
        case (state_q)
            IDLE: begin
                // The winner is always a valid requester, so a grant is an accept.
                req_ready = pick_oh;
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    ctrl_d  = bus.req_control[2*int'(pick_idx) +: 2];
                    opa_d   = bus.req_opA[WIDTH*int'(pick_idx) +: WIDTH];
                    opb_d   = bus.req_opB[WIDTH*int'(pick_idx) +: WIDTH];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_control = ctrl_q;
                alu_opA     = opa_q;
                alu_opB     = opb_q;
                res_d       = bus.alu_result;
                zero_d      = bus.alu_ulaZero;
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid = gnt_oh;
                if (rsp_take) begin
                    state_d = IDLE;
`ifndef ULA_ARB_FIXED_PRIORITY_EN
                    ptr_d   = (gnt_q == IDXW'(N_REQ-1)) ? '0 : gnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ctrl_q  <= 2'b00;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ctrl_q  <= ctrl_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

`ifndef ULA_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_result  = res_q;
    assign bus.rsp_ulaZero = zero_q;
    assign bus.alu_control = alu_control;
    assign bus.alu_opA     = alu_opA;
    assign bus.alu_opB     = alu_opB;
    assign bus.busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ula_arbiter.sv
//------------------------------------------------------------------------------
// tb_ula_arbiter
// Self-checking bench: vector table, scoreboard, arbitration/backpressure/reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ula_arbiter;
    import ula_pkg::*;

    localparam int N = 2;
    localparam int W = 20;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ula_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    ula_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Stand-in for the shared ULA instance.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_control)
            ULA_ADD: bus.alu_result = bus.alu_opA + bus.alu_opB;
            ULA_OR:  bus.alu_result = bus.alu_opA | bus.alu_opB;
            ULA_AND: bus.alu_result = bus.alu_opA & bus.alu_opB;
            default: bus.alu_result = ~bus.alu_opA;
        endcase
        bus.alu_ulaZero = (bus.alu_opA == bus.alu_opB);
    end

    typedef struct {
        int         idx;
        logic [1:0] ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic       zero;
    } vec_t;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       zero;
    } exp_t;

    vec_t         tab [8];
    exp_t         sb [$];
    logic [W-1:0] pend_res  [N];
    logic         pend_zero [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    e.idx  = i;
                    e.res  = pend_res[i];
                    e.zero = pend_zero[i];
                    sb.push_back(e);
                end
            end
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rsp_owner", 32'(bus.rsp_valid), 32'd1 << e.idx);
                    chk("sb_result", 32'(bus.rsp_result), 32'(e.res));
                    chk("sb_ulaZero", 32'(bus.rsp_ulaZero), 32'(e.zero));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] r, input logic z);
        bus.req_control[2*i +: 2] = c;
        bus.req_opA[W*i +: W]     = a;
        bus.req_opB[W*i +: W]     = b;
        pend_res[i]               = r;
        pend_zero[i]              = z;
        bus.req_valid[i]          = 1'b1;
    endtask

    task automatic wait_ready(input int i);
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (bus.req_ready[i]) ok = 1;
        end
        chk("req_ready_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int i);
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (bus.rsp_valid[i]) ok = 1;
        end
        chk("rsp_valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        set_req(v.idx, v.ctrl, v.a, v.b, v.res, v.zero);
        wait_ready(v.idx);
        chk("req_ready_onehot", 32'(bus.req_ready), 32'd1 << v.idx);
        @(posedge clk); #1;
        bus.req_valid[v.idx] = 1'b0;
        @(negedge clk);
        chk("exec_busy", 32'(bus.busy), 32'd1);
        chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("exec_alu_opA", 32'(bus.alu_opA), 32'(v.a));
        chk("exec_alu_control", 32'(bus.alu_control), 32'(v.ctrl));
        @(negedge clk);
        chk("rsp_valid_t2", 32'(bus.rsp_valid), 32'd1 << v.idx);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_alu_opA", 32'(bus.alu_opA), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        tab[0] = '{0, ULA_ADD, 20'h00001, 20'h00001, 20'h00002, 1'b1};
        tab[1] = '{1, ULA_NOT, 20'hFFC00, 20'h00000, 20'h003FF, 1'b0};
        tab[2] = '{0, ULA_ADD, 20'hFFFFF, 20'h00001, 20'h00000, 1'b0};
        tab[3] = '{1, ULA_OR,  20'hFFC00, 20'h00003, 20'hFFC03, 1'b0};
        tab[4] = '{0, ULA_AND, 20'h00205, 20'h0000F, 20'h00005, 1'b0};
        tab[5] = '{1, ULA_AND, 20'h12345, 20'h12345, 20'h12345, 1'b1};
        tab[6] = '{0, ULA_OR,  20'h00000, 20'h00000, 20'h00000, 1'b1};
        tab[7] = '{1, ULA_NOT, 20'h00000, 20'hABCDE, 20'hFFFFF, 1'b0};

        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_control = '0;
        bus.req_opA     = '0;
        bus.req_opB     = '0;
        bus.rsp_ready   = '0;
        for (int i = 0; i < N; i++) begin
            pend_res[i]  = '0;
            pend_zero[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_rsp_ulaZero", 32'(bus.rsp_ulaZero), 32'd0);
        chk("rst_alu_opA", 32'(bus.alu_opA), 32'd0);
        chk("rst_alu_opB", 32'(bus.alu_opB), 32'd0);
        chk("rst_alu_control", 32'(bus.alu_control), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = '1;

        // Both requesters valid in the same cycle straight after reset.
        @(posedge clk); #1;
        set_req(0, ULA_OR,  20'hFFC00, 20'h00003, 20'hFFC03, 1'b0);
        set_req(1, ULA_AND, 20'h00205, 20'h0000F, 20'h00005, 1'b0);
        @(negedge clk);
        chk("arb_first_req0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk); #1;
        set_req(0, ULA_ADD, 20'h00002, 20'h00003, 20'h00005, 1'b0);
        @(negedge clk);
`ifdef ULA_ARB_FIXED_PRIORITY_EN
        chk("arb_fixed_req0_again", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk); #1;
        set_req(0, ULA_ADD, 20'h00004, 20'h00004, 20'h00008, 1'b1);
        @(negedge clk);
        chk("arb_fixed_req1_starved", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb_fixed_req1_last", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(1);
        @(posedge clk); #1;
`else
        chk("arb_rr_req1_next", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb_rr_req0_back", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk); #1;
`endif

        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_vec(tab[k]);
        end

        // Backpressure: req0 response held, req1 waiting throughout.
        bus.rsp_ready = '0;
        @(posedge clk); #1;
        set_req(0, ULA_ADD, 20'h12340, 20'h00005, 20'h12345, 1'b0);
        @(negedge clk);
        chk("bp_accept_req0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        set_req(1, ULA_OR, 20'h0F0F0, 20'h00F0F, 20'h0FFFF, 1'b0);
        @(negedge clk);
        chk("bp_exec_no_ready", 32'(bus.req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_result_held", 32'(bus.rsp_result), 32'h12345);
            chk("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp_wrong_ready_ignored", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        bus.rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_in_resp", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_req1_after_hs", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(1);
        @(posedge clk); #1;

        // Reset during EXEC drops the operation and clears the pointer.
        run_vec(tab[0]);
        @(posedge clk); #1;
        set_req(0, ULA_ADD, 20'h00007, 20'h00007, 20'h0000E, 1'b1);
        @(negedge clk);
        chk("rx_accept_req0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rx_in_exec", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rx_busy", 32'(bus.busy), 32'd0);
        chk("rx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rx_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rx_rsp_ulaZero", 32'(bus.rsp_ulaZero), 32'd0);
        chk("rx_alu_opA", 32'(bus.alu_opA), 32'd0);
        chk("rx_alu_control", 32'(bus.alu_control), 32'd0);
        chk("rx_req_ready", 32'(bus.req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rx_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        set_req(0, ULA_OR,  20'h00F00, 20'h000F0, 20'h00FF0, 1'b0);
        set_req(1, ULA_NOT, 20'h0000F, 20'h0000F, 20'hFFFF0, 1'b1);
        @(negedge clk);
        chk("rx_ptr_zero", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rx_req1_next", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(1);
        @(posedge clk); #1;
        repeat (2) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
